regfile_sb: RTL
===============

# regfile_sb

Parametrised register file for the picoMIPS datapath with two write ports, combinational read ports with optional write-bypass, an optional hard-wired zero register, a per-register scoreboard for long-latency (load) results, and a sequenced clear engine. It sits between decode (read addresses, reservations) and write-back (ALU and load results). It provides operands and stall hints to the control unit.

## Interface
- ADDR_WIDTH, 3: register address width; N = 2**ADDR_WIDTH registers.
- DATA_WIDTH, 8: register width in bits.
- ZERO_REG, 1: when 1, r0 reads as 0; writes and reservations to r0 are ignored.
- BYPASS, 1: when 1, same-cycle write data is forwarded to read ports.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- we_a  in  1  write enable, port A (ALU write-back, higher priority).
- waddr_a  in  ADDR_WIDTH  write address, port A.
- wdata_a  in  DATA_WIDTH  write data, port A.
- we_b  in  1  write enable, port B (load write-back; also retires the reservation).
- waddr_b  in  ADDR_WIDTH  write address, port B.
- wdata_b  in  DATA_WIDTH  write data, port B.
- resv  in  1  marks register resv_addr as pending a port-B write.
- resv_addr  in  ADDR_WIDTH  register to reserve.
- raddr1, raddr2  in  ADDR_WIDTH  read addresses.
- data1_q, data2_q  out  DATA_WIDTH  read data, combinational.
- busy1, busy2  out  1  the register at raddr1/raddr2 has a pending port-B write.
- clr_req  in  1  request a sweep clear of all registers.
- clr_busy  out  1  high while the clear sweep runs.

## Operation
- Storage: N x DATA_WIDTH array and an N-bit busy vector.
- Write priority: port A beats port B to the same address in the same cycle. B's data is dropped, but B still clears that busy bit.
- Reservation: resv sets busy[resv_addr] at the edge. A port-B write clears busy[waddr_b]. If resv and the port-B write hit the same address in the same cycle, resv wins and the bit stays set. Port A never touches busy bits.
- Read path: data_q = gpr[raddr].
  - With BYPASS=1, a same-cycle write to raddr is forwarded instead: wdata_a if we_a matches, otherwise wdata_b if we_b matches.
  - With ZERO_REG=1 and raddr=0, data_q = 0 regardless of stored value or bypass.
- busy1/2 = busy[raddr]. With BYPASS=1 this is masked low when we_b writes that address in the same cycle. With ZERO_REG=1 it is always 0 for r0.
- Clear FSM, states IDLE and CLEAR, with an ADDR_WIDTH-bit index:
  - IDLE & clr_req at an edge: go to CLEAR, idx<=0, all busy bits <=0.
  - CLEAR, each edge: gpr[idx]<=0, idx<=idx+1. Once idx=N-1 has been cleared, return to IDLE. The index wraps to 0, with no overflow state.
  - In CLEAR, we_a, we_b, resv and clr_req are ignored, so no array or busy update occurs from them.
  - Reads stay live during CLEAR. Bypass is suppressed while in CLEAR.
- clr_busy = (state == CLEAR).

## Timing
- Reset (reset_n low, asynchronous): all gpr = 0, busy = 0, state IDLE, idx = 0. Outputs settle to data1_q = data2_q = 0, busy1 = busy2 = 0, clr_busy = 0.
- Release of reset_n is honoured at the next clk edge.
- Writes, reservations and clears commit at the rising edge. Reads are zero-latency combinational.
- A write at edge t is visible through the array from edge t onward. With BYPASS=1 it is also visible in the cycle before edge t.
- clr_req sampled at edge t0: clr_busy is high from t0 for exactly N cycles. Register i is cleared at edge t0+1+i. The state is IDLE after edge t0+N.
- Reset asserted during CLEAR aborts the sweep immediately to IDLE. The sweep does not restart after reset.
- resv and clr_req are level-sampled. Holding clr_req high re-enters CLEAR one cycle after the previous sweep completes.

## Test plan
1. Reset, then we_a=1 waddr_a=3 wdata_a=0x5A -> data1_q=0x5A in the same cycle (bypass) and after the edge with we_a=0. reset_n=0 -> data1_q=0x00 immediately, without waiting for clk.
2. Same cycle we_a waddr_a=2 wdata_a=0x11 and we_b waddr_b=2 wdata_b=0x22, with busy[2]=1 beforehand -> gpr[2]=0x11 and busy2=0 after the edge.
3. resv with resv_addr=5 -> busy1=1 for raddr1=5 from the next cycle. Later we_b waddr_b=5 wdata_b=0x7E -> busy1=0 and data1_q=0x7E in the same cycle. resv and we_b both to 5 in one cycle -> busy stays 1.
4. ZERO_REG=1: we_a waddr_a=0 wdata_a=0xFF, and resv_addr=0 -> data1_q=0x00 and busy1=0 for raddr1=0.
5. Registers 1..7 loaded with 0x01..0x07, then a one-cycle clr_req -> clr_busy high for 8 cycles. A we_a to r4 issued mid-sweep is ignored. All registers read 0x00 afterwards and all busy bits are 0.
6. reset_n pulsed low in the 3rd cycle of a clear -> clr_busy=0 immediately, all registers 0, and the next clr_req starts a full 8-cycle sweep.

Source files
------------

// File: rtl/regfile_sb.sv
// picoMIPS register file: two write ports, combinational reads with optional
// bypass, optional hard-wired r0, load scoreboard and a sequenced clear sweep.
module regfile_sb #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] waddr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] waddr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  input  logic                  resv,
  input  logic [ADDR_WIDTH-1:0] resv_addr,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] data1_q,
  output logic [DATA_WIDTH-1:0] data2_q,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  clr_req,
  output logic                  clr_busy
);

  localparam int unsigned N = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
  localparam bit HAS_ZERO = (ZERO_REG != 0);
  localparam bit HAS_BYP  = (BYPASS != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0] gpr_q [N];
  logic [N-1:0]          busy_q;
  logic [N-1:0]          busy_d;
  logic                  clearing;
  logic                  wr_a_ok;
  logic                  wr_b_ok;
  logic                  resv_ok;

  assign clearing = (state_q == CLEAR);
  assign wr_a_ok  = we_a && !(HAS_ZERO && (waddr_a == '0));
  assign wr_b_ok  = we_b && !(HAS_ZERO && (waddr_b == '0));
  assign resv_ok  = resv && !(HAS_ZERO && (resv_addr == '0));
  assign clr_busy = clearing;

  // Scoreboard update: a load retires its bit, a same-cycle reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_b_ok) busy_d[waddr_b] = 1'b0;
    if (resv_ok) busy_d[resv_addr] = 1'b1;
  end

  // State, sweep index, register array and scoreboard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < N; i++) gpr_q[i] <= '0;
    end else if (clearing) begin
      gpr_q[idx_q] <= '0;
      idx_q        <= idx_q + ADDR_WIDTH'(1);
      if (idx_q == LAST_IDX) state_q <= IDLE;
    end else begin
      if (wr_b_ok) gpr_q[waddr_b] <= wdata_b;
      if (wr_a_ok) gpr_q[waddr_a] <= wdata_a;
      if (clr_req) begin
        state_q <= CLEAR;
        idx_q   <= '0;
        busy_q  <= '0;
      end else begin
        busy_q <= busy_d;
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd_data(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] d;
    d = gpr_q[a];
    if (HAS_BYP && !clearing) begin
      if (we_b && (waddr_b == a)) d = wdata_b;
      if (we_a && (waddr_a == a)) d = wdata_a;
    end
    if (HAS_ZERO && (a == '0)) d = '0;
    return d;
  endfunction

  function automatic logic rd_busy(input logic [ADDR_WIDTH-1:0] a);
    logic b;
    b = busy_q[a];
    if (HAS_BYP && !clearing && we_b && (waddr_b == a)) b = 1'b0;
    if (HAS_ZERO && (a == '0)) b = 1'b0;
    return b;
  endfunction

  // Zero-latency read ports.
  always_comb begin
    data1_q = rd_data(raddr1);
    data2_q = rd_data(raddr2);
    busy1   = rd_busy(raddr1);
    busy2   = rd_busy(raddr2);
  end

endmodule
